// File: rtl/dmem_dma_master.sv
// Word-copy bus initiator on the data-memory/IO port; define DMA_FILL_EN to add a constant-fill mode.
// Latency: 2*len+2 cycles from start to done with continuous grant (len+2 in fill mode).
// Backpressure: bus_gnt low in REQ/RD/WR freezes state, pointers and count; no capture, no write.
module dmem_dma_master #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 6
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
`ifdef DMA_FILL_EN
    input  logic              fill,
    input  logic [31:0]       fill_data,
`endif
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_datain,
    output logic              mem_we,
    input  logic [31:0]       mem_dataout,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_datain;
    logic              r_bus_req;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_fill_in;
    logic              w_fill_mode;
    logic [31:0]       w_fill_word;
    logic              w_misaligned;

`ifdef DMA_FILL_EN
    logic              r_fill;
    logic [31:0]       r_fill_data;

    assign w_fill_in   = fill;
    assign w_fill_mode = r_fill;
    assign w_fill_word = r_fill_data;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_fill      <= 1'b0;
            r_fill_data <= 32'd0;
        end else if (r_state == IDLE && start) begin
            r_fill      <= fill;
            r_fill_data <= fill_data;
        end
    end
`else
    assign w_fill_in   = 1'b0;
    assign w_fill_mode = 1'b0;
    assign w_fill_word = 32'd0;
`endif

    // Fill mode never reads, so the source alignment is irrelevant there.
    assign w_misaligned = (dst_addr[1:0] != 2'b00) ||
                          (!w_fill_in && (src_addr[1:0] != 2'b00));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_src        <= '0;
            r_dst        <= '0;
            r_cnt        <= '0;
            r_mem_addr   <= '0;
            r_mem_datain <= 32'd0;
            r_bus_req    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_misaligned) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= FIN;
                        end else if (len == '0) begin
                            r_err   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            r_src      <= src_addr;
                            r_dst      <= dst_addr;
                            r_cnt      <= len;
                            r_mem_addr <= src_addr;
                            r_err      <= 1'b0;
                            r_busy     <= 1'b1;
                            r_bus_req  <= 1'b1;
                            r_state    <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        if (w_fill_mode) begin
                            r_mem_addr   <= r_dst;
                            r_mem_datain <= w_fill_word;
                            r_state      <= WR;
                        end else begin
                            r_mem_addr <= r_src;
                            r_state    <= RD;
                        end
                    end
                end
                RD: begin
                    if (bus_gnt) begin
                        r_mem_datain <= mem_dataout;
                        r_src        <= r_src + ADDR_W'(4);
                        r_mem_addr   <= r_dst;
                        r_state      <= WR;
                    end
                end
                WR: begin
                    if (bus_gnt) begin
                        r_dst <= r_dst + ADDR_W'(4);
                        r_cnt <= r_cnt - LEN_W'(1);
                        if (r_cnt == LEN_W'(1)) begin
                            r_bus_req <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= FIN;
                        end else if (w_fill_mode) begin
                            r_mem_addr <= r_dst + ADDR_W'(4);
                        end else begin
                            r_mem_addr <= r_src;
                            r_state    <= RD;
                        end
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_we     = (r_state == WR) && bus_gnt;
    assign mem_addr   = r_mem_addr;
    assign mem_datain = r_mem_datain;
    assign bus_req    = r_bus_req;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_dmem_dma_master.sv
// Bench for dmem_dma_master: word-array memory map model, reference copy model and write/done scoreboard.
module tb_dmem_dma_master;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [5:0]  len;
`ifdef DMA_FILL_EN
    logic        fill;
    logic [31:0] fill_data;
`endif
    logic        bus_req;
    logic        bus_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_datain;
    logic        mem_we;
    logic [31:0] mem_dataout;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clock = ~clock;

    dmem_dma_master #(.ADDR_W(32), .LEN_W(6)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .len         (len),
`ifdef DMA_FILL_EN
        .fill        (fill),
        .fill_data   (fill_data),
`endif
        .bus_req     (bus_req),
        .bus_gnt     (bus_gnt),
        .mem_addr    (mem_addr),
        .mem_datain  (mem_datain),
        .mem_we      (mem_we),
        .mem_dataout (mem_dataout),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // 64 words: 0x00-0x7C RAM, 0x80-0xFC IO registers (out_port0 at 0x80).
    logic [31:0] mem   [64];
    logic [31:0] ref_m [64];

    always @(posedge clock)
        if (mem_we && resetn) mem[mem_addr[7:2]] <= mem_datain;
    assign mem_dataout = mem[mem_addr[7:2]];

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic err; int lat; logic req; } dn_t;
    wr_t wq[$];
    dn_t dq[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops an expected write for every mem_we cycle and an expected completion for every done pulse.
    int cyc = 0, st_cyc = 0, lows = 0;
    bit req_seen = 0;
    always @(negedge clock) begin
        wr_t w;
        dn_t d;
        cyc++;
        if (resetn) begin
            if (mem_we) begin
                chk("we_with_gnt", {31'd0, bus_gnt}, 32'd1);
                if (wq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected none", mem_addr, mem_datain);
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", mem_addr, w.addr);
                    chk("wr_data", mem_datain, w.data);
                end
            end
            if (start) begin
                st_cyc = cyc; lows = 0; req_seen = 0;
            end else begin
                if (bus_req) req_seen = 1;
                if (done) begin
                    if (dq.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_done: got done, expected none");
                    end else begin
                        d = dq.pop_front();
                        chk("done_err", {31'd0, err}, {31'd0, d.err});
                        chk("done_latency", 32'(cyc - st_cyc), 32'(d.lat + lows));
                        chk("bus_req_seen", {31'd0, req_seen}, {31'd0, d.req});
                        chk("req_low_at_done", {31'd0, bus_req}, 32'd0);
                        chk("busy_low_at_done", {31'd0, busy}, 32'd0);
                    end
                end else if (!bus_gnt) begin
                    lows++;
                end
            end
        end
    end

    // Model the transfer, then drive it; rst_at>0 pulls reset in that cycle after start.
    task automatic go(input logic [31:0] s, input logic [31:0] d, input int n, input logic f,
                      input logic [31:0] fd, input bit rnd, input int stall_from, input int stall_n,
                      input int rst_at);
        dn_t e;
        wr_t w;
        int words;
        bit mis;
        logic [31:0] a;
        mis   = (d[1:0] != 2'b00) || (!f && s[1:0] != 2'b00);
        words = (rst_at > 0) ? (rst_at - 3) / 2 : n;
        if (mis) begin
            e.err = 1'b1; e.lat = 1; e.req = 1'b0; dq.push_back(e);
        end else if (n == 0) begin
            e.err = 1'b0; e.lat = 1; e.req = 1'b0; dq.push_back(e);
        end else begin
            for (int i = 0; i < words; i++) begin
                w.addr = d + 32'(4 * i);
                a      = s + 32'(4 * i);
                w.data = f ? fd : ref_m[a[7:2]];
                ref_m[w.addr[7:2]] = w.data;
                wq.push_back(w);
            end
            if (rst_at == 0) begin
                e.err = 1'b0; e.lat = f ? n + 2 : 2 * n + 2; e.req = 1'b1; dq.push_back(e);
            end
        end
        @(posedge clock); #1;
        src_addr = s; dst_addr = d; len = n[5:0]; start = 1'b1; bus_gnt = 1'b1;
`ifdef DMA_FILL_EN
        fill = f; fill_data = fd;
`endif
        for (int k = 1; k <= 400; k++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (rst_at > 0 && k == rst_at + 1) begin
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
                chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
                chk("rst_done", {31'd0, done}, 32'd0);
                resetn = 1'b1;
                return;
            end
            if (k == rst_at) resetn = 1'b0;
            if (stall_n > 0 && k >= stall_from && k < stall_from + stall_n) bus_gnt = 1'b0;
            else if (rnd) bus_gnt = ($urandom % 4) != 0;
            else bus_gnt = 1'b1;
            if (rst_at == 0 && !busy && !done && dq.size() == 0) return;
        end
        n_chk++; n_fail++;
        $display("FAIL timeout: transfer still open after 400 cycles, expected completion");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s, d;
        int n, r;
        logic f;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        mem[4] = 32'hA5A5A5A5;
        for (int i = 0; i < 64; i++) ref_m[i] = mem[i];

        resetn = 1'b0; start = 1'b0; src_addr = 0; dst_addr = 0; len = 0; bus_gnt = 1'b1;
`ifdef DMA_FILL_EN
        fill = 1'b0; fill_data = 0;
`endif
        repeat (3) @(posedge clock);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_bus_req", {31'd0, bus_req}, 32'd0);
        chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_mem_datain", mem_datain, 32'd0);
        resetn = 1'b1;

        go(32'h00, 32'h40, 4, 1'b0, 0, 1'b0, 0, 0, 0);       // 4-word copy, done after 10 cycles
        go(32'h10, 32'h80, 1, 1'b0, 0, 1'b0, 0, 0, 0);       // RAM -> out_port0
        go(32'h00, 32'h60, 2, 1'b0, 0, 1'b0, 3, 3, 0);       // 3-cycle grant stall in WR of word 0
        go(32'h04, 32'h48, 0, 1'b0, 0, 1'b0, 0, 0, 0);       // len 0
        go(32'h02, 32'h48, 3, 1'b0, 0, 1'b0, 0, 0, 0);       // misaligned source
        chk("err_sticky", {31'd0, err}, 32'd1);
        go(32'h08, 32'h50, 1, 1'b0, 0, 1'b0, 0, 0, 0);       // clears err
        chk("err_cleared", {31'd0, err}, 32'd0);
        go(32'h00, 32'h20, 5, 1'b0, 0, 1'b0, 0, 0, 7);       // reset during WR of word 2
        go(32'h24, 32'h70, 3, 1'b0, 0, 1'b0, 0, 0, 0);       // normal after reset
`ifdef DMA_FILL_EN
        go(32'h00, 32'h20, 3, 1'b1, 32'hDEADBEEF, 1'b0, 0, 0, 0);
`endif

        for (int t = 0; t < 40; t++) begin
            r = $urandom % 10;
            s = ($urandom % 64) * 4;
            d = ($urandom % 64) * 4;
            n = 1 + $urandom % 8;
            f = 1'b0;
`ifdef DMA_FILL_EN
            f = ($urandom % 3) == 0;
            if (f) s[1:0] = 2'($urandom);
`endif
            if (r == 0) begin
                if ($urandom % 2 == 0) d[1:0] = 2'(1 + $urandom % 3);
                else begin s[1:0] = 2'(1 + $urandom % 3); f = 1'b0; end
            end else if (r == 1) begin
                n = 0;
            end
            go(s, d, n, f, $urandom, 1'b1, 0, 0, 0);
        end

        repeat (3) @(posedge clock);
        #1;
        chk("writes_drained", 32'(wq.size()), 32'd0);
        chk("dones_drained", 32'(dq.size()), 32'd0);
        for (int i = 0; i < 64; i++) chk($sformatf("mem[0x%02h]", i * 4), mem[i], ref_m[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_dma_master.md
Name: dmem_dma_master

Overview:
- Bus initiator that drives the data-memory/IO load-store interface (addr, datain, we, dataout) instead of the CPU.
- Copies a block of words from a source to a destination byte address, one word at a time, through the same address map as the CPU: addr[7]=0 is RAM, addr[7]=1 is the IO registers.
- Arbitrates with the CPU through a req/gnt handshake.
- Sits beside the CPU at the data-memory port; the top level muxes its address, data and write-enable onto the port while granted.

Parameters:
- ADDR_W, 32, width of byte addresses.
- LEN_W, 6, width of the word-count input; maximum transfer is 2^LEN_W-1 words.

Ports:
- clock  input  1  system clock (same clock as the CPU); all state changes on the rising edge.
- resetn  input  1  synchronous active-low reset, sampled on the rising edge of clock.
- start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
- src_addr  input  ADDR_W  source byte address; must be word-aligned.
- dst_addr  input  ADDR_W  destination byte address; must be word-aligned.
- len  input  LEN_W  number of 32-bit words to copy.
- bus_req  output  1  request for the data-memory port.
- bus_gnt  input  1  port granted to this block.
- mem_addr  output  ADDR_W  address to the data-memory port.
- mem_datain  output  32  write data to the data-memory port.
- mem_we  output  1  write enable to the data-memory port.
- mem_dataout  input  32  read data from the data-memory port; valid by the end of the cycle its address is presented.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse when a transfer completes or is rejected.
- err  output  1  sticky misalignment flag; cleared by the next accepted start.

Behaviour:
- States: IDLE, REQ, RD, WR, FIN.
- Reset (resetn=0 at an edge, in any state including mid-transfer):
  - state=IDLE; busy, done, err, bus_req all 0.
  - mem_addr=0, mem_datain=0, internal counters and capture register cleared.
  - mem_we is 0 from that edge on, so no write completes after reset.
- IDLE, start=1:
  - If src_addr[1:0]!=0 or dst_addr[1:0]!=0: err=1, go to FIN, no bus access.
  - Else if len==0: err=0, go to FIN, no bus access.
  - Else: latch src, dst and len into internal pointers and counter; err=0; busy=1; bus_req=1; go to REQ.
- REQ: wait for bus_gnt=1, then go to RD. bus_req stays 1 from REQ until FIN is entered.
- RD: mem_addr=src pointer, mem_we=0. At the edge with bus_gnt=1: capture mem_dataout, src+=4, go to WR.
- WR: mem_addr=dst pointer, mem_datain=captured word, mem_we=1. At the edge with bus_gnt=1: dst+=4, count-=1. If count reaches 0 go to FIN, else go to RD.
- Grant loss:
  - mem_we = (state==WR) & bus_gnt.
  - While bus_gnt=0 in RD or WR: state, pointers and count hold; no capture; no write.
- Throughput: 2 cycles per word under continuous grant. Latency from start to done is 2*len+2 cycles with immediate grant.
- FIN: bus_req=0, busy=0, done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- Pointers increment modulo 2^ADDR_W; wrap-around is not an error.
- Overlapping source/destination ranges are copied in ascending address order with no hazard protection.
- Outputs are registered except mem_we, which is combinational as defined above.

Optional Feature:
- Macro DMA_FILL_EN.
- Defined:
  - Adds input fill (1 bit) and input fill_data (32 bits), both latched at start.
  - With fill=1 the block skips RD and loops in WR, writing fill_data to consecutive dst words at 1 cycle per word.
  - src_addr alignment is not checked when fill=1.
- Undefined: the ports do not exist and the block always copies.

Test Plan:
- Copy 4 words: RAM 0x00..0x0C preloaded 0x11,0x22,0x33,0x44; start with src=0x00, dst=0x40, len=4, grant held high -> RAM 0x40..0x4C hold 0x11..0x44; done pulses 10 cycles after start; bus_req falls with done.
- Write to IO: src=0x10 holding 0xA5A5A5A5; dst=0x80, len=1 -> out_port0 reads 0xA5A5A5A5 and no RAM location changes.
- Grant stall: len=2, with bus_gnt dropped for 3 cycles while in WR of word 0 -> mem_we stays 0 during the stall; final memory matches the copy; done is 3 cycles later than the unstalled case.
- Boundaries:
  - len=0 -> done 1 cycle after start, err=0, no mem_we pulse.
  - src=0x02 -> done pulses, err=1, no bus_req.
  - A following valid start clears err.
- Reset mid-transfer: resetn low during WR of word 2 of 5 -> busy=0, bus_req=0, mem_we=0 from that edge; words 0-1 written, words 2-4 untouched; a new start then works normally.
- With DMA_FILL_EN defined: fill=1, fill_data=0xDEADBEEF, dst=0x20, len=3 -> 0x20..0x28 hold 0xDEADBEEF; done 5 cycles after start; no RD cycles occur.
